// File: rtl/wish_width_splitter.sv
// Wishbone width splitter: accepts one beat of N packed words and replays it
// as N single-word beats, with the last-beat tag only on the final word.
module wish_width_splitter #(
  parameter int DATA_WIDTH    = 32,
  parameter int N             = 2,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  input  logic [DATA_WIDTH*N-1:0] dat_i,
  input  logic [1:0]              tgc_i,
  output logic                    ack_o,
  output logic                    stb_o,
  output logic                    cyc_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic [1:0]              tgc_o,
  input  logic                    ack_i
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  generate
    if (N < 1) begin : g_bad_n
      $error("wish_width_splitter: N must be >= 1");
    end
  endgenerate

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH*N-1:0] buf_q, buf_d;
  logic [DATA_WIDTH*N-1:0] words_in;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [1:0]              tag_q, tag_d;
  logic                    is_last;
  logic                    in_xfer;
  logic                    out_xfer;

  // The buffer holds words already in emission order: slot k is word k.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_order
      if (LITTLE_ENDIAN) begin : g_le
        assign words_in[gi*DATA_WIDTH +: DATA_WIDTH] = dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_be
        assign words_in[gi*DATA_WIDTH +: DATA_WIDTH] = dat_i[(N-1-gi)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  endgenerate

  assign is_last  = (idx_q == LAST_IDX);
  assign ack_o    = !rst_i && ((state_q == EMPTY) || ((state_q == SEND) && is_last && ack_i));
  assign in_xfer  = stb_i && cyc_i && ack_o;
  assign out_xfer = (state_q == SEND) && ack_i;

  assign stb_o = (state_q == SEND);
  assign cyc_o = (state_q == SEND);
  assign dat_o = dat_q;
  assign tgc_o = {tag_q[1], tag_q[0] & is_last};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    dat_d   = dat_q;
    tag_d   = tag_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          buf_d   = words_in;
          dat_d   = words_in[DATA_WIDTH-1:0];
          tag_d   = tgc_i;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (!is_last) begin
            idx_d = idx_q + 1'b1;
            dat_d = buf_q[(32'(idx_q) + 1) * DATA_WIDTH +: DATA_WIDTH];
          end else if (in_xfer) begin
            // Reload on the last word keeps the stream gap-free.
            buf_d = words_in;
            dat_d = words_in[DATA_WIDTH-1:0];
            tag_d = tgc_i;
            idx_d = '0;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      buf_q   <= '0;
      dat_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      dat_q   <= dat_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_wish_width_splitter.sv
// Self-checking bench: three splitter instances (N=2 LE, N=2 BE, N=1) share
// stimulus; directed scenarios plus a randomized run against a word-queue model.
module tb_wish_width_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        ack_in = 1'b0;
  logic [63:0] dat = '0;
  logic [1:0]  tgc = '0;

  logic        ack_w [3];
  logic        stb_w [3];
  logic        cyc_w [3];
  logic [31:0] dat_w [3];
  logic [1:0]  tgc_w [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per instance, queue of pending {tag, word} items still to be emitted.
  logic [33:0] mq [3][$];

  always #5 clk = ~clk;

  wish_width_splitter #(.DATA_WIDTH(32), .N(2), .LITTLE_ENDIAN(1'b1)) u_le (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .cyc_i(cyc), .dat_i(dat), .tgc_i(tgc),
    .ack_o(ack_w[0]), .stb_o(stb_w[0]), .cyc_o(cyc_w[0]), .dat_o(dat_w[0]),
    .tgc_o(tgc_w[0]), .ack_i(ack_in));

  wish_width_splitter #(.DATA_WIDTH(32), .N(2), .LITTLE_ENDIAN(1'b0)) u_be (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .cyc_i(cyc), .dat_i(dat), .tgc_i(tgc),
    .ack_o(ack_w[1]), .stb_o(stb_w[1]), .cyc_o(cyc_w[1]), .dat_o(dat_w[1]),
    .tgc_o(tgc_w[1]), .ack_i(ack_in));

  wish_width_splitter #(.DATA_WIDTH(32), .N(1), .LITTLE_ENDIAN(1'b1)) u_n1 (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .cyc_i(cyc), .dat_i(dat[31:0]), .tgc_i(tgc),
    .ack_o(ack_w[2]), .stb_o(stb_w[2]), .cyc_o(cyc_w[2]), .dat_o(dat_w[2]),
    .tgc_o(tgc_w[2]), .ack_i(ack_in));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic c, input logic [63:0] d,
                       input logic [1:0] t, input logic a);
    stb = s; cyc = c; dat = d; tgc = t; ack_in = a;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b1);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 64'h0000_0002_0000_0001, 2'b11, 1'b1);
    n_checks++;
    if (ack_w[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ack: ack_o=%b expected 0", ack_w[0]); end
    tick();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({stb_w[d], cyc_w[d], dat_w[d], tgc_w[d]} !== 36'h0)
        begin n_fail++; $display("FAIL reset_outs[%0d]: stb=%b cyc=%b dat=%h tgc=%b expected all 0", d, stb_w[d], cyc_w[d], dat_w[d], tgc_w[d]); end
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b1);
    n_checks++;
    if (ack_w[0] !== 1'b1) begin n_fail++; $display("FAIL reset_empty_ack: ack_o=%b expected 1", ack_w[0]); end
    $display("test_reset done");
  endtask

  task automatic test_order();
    do_reset();
    drive(1'b1, 1'b1, 64'h0000_0002_0000_0001, 2'b01, 1'b1);
    n_checks++;
    if (stb_w[0] !== 1'b0) begin n_fail++; $display("FAIL order_pre_stb: stb_o=%b expected 0", stb_w[0]); end
    tick();
    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b1);
    n_checks++;
    if ({stb_w[0], dat_w[0], tgc_w[0]} !== {1'b1, 32'h1, 2'b00})
      begin n_fail++; $display("FAIL le_word0: stb=%b dat=%h tgc=%b expected 1 00000001 00", stb_w[0], dat_w[0], tgc_w[0]); end
    n_checks++;
    if ({dat_w[1], tgc_w[1]} !== {32'h2, 2'b00})
      begin n_fail++; $display("FAIL be_word0: dat=%h tgc=%b expected 00000002 00", dat_w[1], tgc_w[1]); end
    n_checks++;
    if ({stb_w[2], dat_w[2], tgc_w[2]} !== {1'b1, 32'h1, 2'b01})
      begin n_fail++; $display("FAIL n1_word: stb=%b dat=%h tgc=%b expected 1 00000001 01", stb_w[2], dat_w[2], tgc_w[2]); end
    tick();
    n_checks++;
    if ({stb_w[0], dat_w[0], tgc_w[0], ack_w[0]} !== {1'b1, 32'h2, 2'b01, 1'b1})
      begin n_fail++; $display("FAIL le_word1: stb=%b dat=%h tgc=%b ack=%b expected 1 00000002 01 1", stb_w[0], dat_w[0], tgc_w[0], ack_w[0]); end
    n_checks++;
    if ({dat_w[1], tgc_w[1]} !== {32'h1, 2'b01})
      begin n_fail++; $display("FAIL be_word1: dat=%h tgc=%b expected 00000001 01", dat_w[1], tgc_w[1]); end
    tick();
    n_checks++;
    if ({stb_w[0], cyc_w[0], stb_w[1]} !== 3'b000)
      begin n_fail++; $display("FAIL order_done: stb=%b cyc=%b be_stb=%b expected 0 0 0", stb_w[0], cyc_w[0], stb_w[1]); end
    $display("test_order done");
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 1'b1, 64'h0000_0002_0000_0001, 2'b01, 1'b1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 1'b0, 64'h0, 2'b00, (c == 4));
      n_checks++;
      if ({stb_w[0], dat_w[0], ack_w[0]} !== {1'b1, 32'h1, 1'b0})
        begin n_fail++; $display("FAIL bp_hold c=%0d: stb=%b dat=%h ack=%b expected 1 00000001 0", c, stb_w[0], dat_w[0], ack_w[0]); end
      tick();
    end
    n_checks++;
    if ({stb_w[0], dat_w[0], tgc_w[0]} !== {1'b1, 32'h2, 2'b01})
      begin n_fail++; $display("FAIL bp_word1: stb=%b dat=%h tgc=%b expected 1 00000002 01", stb_w[0], dat_w[0], tgc_w[0]); end
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_back_to_back();
    logic [63:0] beat;
    int b;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      b = (c + 1) / 2;
      beat = {32'(2*b + 2), 32'(2*b + 1)};
      drive((c < 5), 1'b1, beat, 2'b00, 1'b1);
      if (c >= 1) begin
        n_checks++;
        if ({stb_w[0], dat_w[0], ack_w[0]} !== {1'b1, 32'(c), (c % 2 == 0)})
          begin n_fail++; $display("FAIL b2b c=%0d: stb=%b dat=%h ack=%b expected 1 %h %b", c, stb_w[0], dat_w[0], ack_w[0], 32'(c), (c % 2 == 0)); end
      end
      tick();
    end
    n_checks++;
    if (stb_w[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_end: stb=%b expected 0", stb_w[0]); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(1'b1, 1'b1, 64'h0000_0002_0000_0001, 2'b01, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b1);
    n_checks++;
    if ({stb_w[0], dat_w[0], ack_w[0]} !== {1'b1, 32'h1, 1'b0})
      begin n_fail++; $display("FAIL mid_pre: stb=%b dat=%h ack=%b expected 1 00000001 0", stb_w[0], dat_w[0], ack_w[0]); end
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 64'h0000_0008_0000_0007, 2'b00, 1'b1);
    n_checks++;
    if ({stb_w[0], cyc_w[0], dat_w[0]} !== {1'b0, 1'b0, 32'h0})
      begin n_fail++; $display("FAIL mid_reset: stb=%b cyc=%b dat=%h expected 0 0 00000000", stb_w[0], cyc_w[0], dat_w[0]); end
    tick();
    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b1);
    n_checks++;
    if ({stb_w[0], dat_w[0]} !== {1'b1, 32'h7})
      begin n_fail++; $display("FAIL mid_restart: stb=%b dat=%h expected 1 00000007", stb_w[0], dat_w[0]); end
    tick();
    tick();
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_cyc_gating();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, {$urandom, $urandom}, 2'b11, 1'b1);
      tick();
      n_checks++;
      if ({stb_w[0], stb_w[2]} !== 2'b00)
        begin n_fail++; $display("FAIL cyc_gate c=%0d: stb_le=%b stb_n1=%b expected 0 0", c, stb_w[0], stb_w[2]); end
    end
    $display("test_cyc_gating done");
  endtask

  task automatic test_n1();
    logic [63:0] v [6];
    logic [1:0]  t [6];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v[i] = {$urandom, $urandom};
      t[i] = 2'($urandom);
    end
    for (int c = 0; c <= 6; c++) begin
      drive((c < 6), 1'b1, (c < 6) ? v[c % 6] : 64'h0, (c < 6) ? t[c % 6] : 2'b00, 1'b1);
      if (c >= 1) begin
        n_checks++;
        if ({stb_w[2], dat_w[2], tgc_w[2]} !== {1'b1, v[c-1][31:0], t[c-1]})
          begin n_fail++; $display("FAIL n1 c=%0d: stb=%b dat=%h tgc=%b expected 1 %h %b", c, stb_w[2], dat_w[2], tgc_w[2], v[c-1][31:0], t[c-1]); end
      end
      tick();
    end
    $display("test_n1 done");
  endtask

  task automatic test_random();
    logic        exp_ack;
    logic        in_x;
    int          nw;
    logic [31:0] w;
    do_reset();
    for (int d = 0; d < 3; d++) mq[d].delete();
    for (int cyc_n = 0; cyc_n < 400; cyc_n++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, {$urandom, $urandom},
            2'($urandom), $urandom_range(0, 9) < 7);
      for (int d = 0; d < 3; d++) begin
        nw = (d == 2) ? 1 : 2;
        exp_ack = !rst && ((mq[d].size() == 0) || (mq[d].size() == 1 && ack_in));
        n_checks++;
        if ({ack_w[d], stb_w[d], cyc_w[d]} !== {exp_ack, mq[d].size() > 0, mq[d].size() > 0})
          begin n_fail++; $display("FAIL rnd_ctl[%0d] cyc=%0d: ack/stb/cyc=%b%b%b expected %b%b%b", d, cyc_n, ack_w[d], stb_w[d], cyc_w[d], exp_ack, mq[d].size() > 0, mq[d].size() > 0); end
        if (mq[d].size() > 0) begin
          n_checks++;
          if ({tgc_w[d], dat_w[d]} !== mq[d][0])
            begin n_fail++; $display("FAIL rnd_dat[%0d] cyc=%0d: tgc=%b dat=%h expected tgc=%b dat=%h", d, cyc_n, tgc_w[d], dat_w[d], mq[d][0][33:32], mq[d][0][31:0]); end
        end
        if (rst) begin
          mq[d].delete();
        end else begin
          in_x = stb && cyc && exp_ack;
          if (mq[d].size() > 0 && ack_in) void'(mq[d].pop_front());
          if (in_x) begin
            if (d == 0) $display("beat in: dat=%h tgc=%b", dat, tgc);
            for (int k = 0; k < nw; k++) begin
              w = (d == 1) ? dat[(nw-1-k)*32 +: 32] : dat[k*32 +: 32];
              mq[d].push_back({tgc[1], (k == nw - 1) ? tgc[0] : 1'b0, w});
            end
          end
        end
      end
      tick();
    end
    rst = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    test_cyc_gating();
    test_n1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
